// File: rtl/dct_1d_stage.sv
// dct_1d_stage: 1x8 1D-DCT stage (row pass on unsigned pixels, column pass on
// signed stage-1 output). A double-buffered input lock feeds a 5-stage even/odd
// butterfly engine that emits F0..F7, one coefficient per clock.
// Optional build macro: DCT_1D_ROUND_EN (round half away from zero in S5;
// when undefined the magnitude is truncated toward zero).
module dct_1d_stage #(
  parameter int IN_WIDTH        = 8,
  parameter int IN_FRACT_WIDTH  = 0,
  parameter bit SIGNED_IN       = 1'b0,
  parameter int OUT_FRACT_WIDTH = 8,
  localparam int OUT_W = IN_WIDTH - IN_FRACT_WIDTH + 2 + OUT_FRACT_WIDTH,
  localparam int TD_W  = ((OUT_W + 7) / 8) * 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [IN_WIDTH-1:0] video_i_tdata,
  input  logic                video_i_tvalid,
  input  logic                video_i_tlast,
  input  logic                video_i_tuser,
  output logic                video_i_tready,
  output logic [TD_W-1:0]     dct_o_tdata,
  output logic [TD_W/8-1:0]   dct_o_tkeep,
  output logic [TD_W/8-1:0]   dct_o_tstrb,
  output logic                dct_o_tvalid,
  output logic                dct_o_tlast,
  output logic                dct_o_tuser,
  input  logic                dct_o_tready
);

  // Coefficients ck = 0.5*cos(k*pi/16) in signed Q0.24; quantisation error stays
  // far below one output LSB even with all four products at full scale.
  localparam int CF     = 24;
  localparam int COEF_W = 24;
  localparam int A_W    = IN_WIDTH + 1;           // butterfly sum/difference
  localparam int P_W    = A_W + COEF_W;           // full-precision product
  localparam int Q_W    = P_W + 1;                // pairwise sum
  localparam int S_W    = P_W + 2;                // final sum
  localparam int SH     = IN_FRACT_WIDTH + CF - OUT_FRACT_WIDTH; // must be >= 1

  localparam logic signed [COEF_W-1:0] C1 = 24'sd8227423;
  localparam logic signed [COEF_W-1:0] C2 = 24'sd7750063;
  localparam logic signed [COEF_W-1:0] C3 = 24'sd6974873;
  localparam logic signed [COEF_W-1:0] C4 = 24'sd5931642;
  localparam logic signed [COEF_W-1:0] C5 = 24'sd4660461;
  localparam logic signed [COEF_W-1:0] C6 = 24'sd3210181;
  localparam logic signed [COEF_W-1:0] C7 = 24'sd1636536;

`ifdef DCT_1D_ROUND_EN
  localparam logic signed [S_W-1:0] POS_BIAS = S_W'(1) <<< (SH - 1);
  localparam logic signed [S_W-1:0] NEG_BIAS = POS_BIAS - S_W'(1);
`else
  localparam logic signed [S_W-1:0] POS_BIAS = '0;
  localparam logic signed [S_W-1:0] NEG_BIAS = (S_W'(1) <<< SH) - S_W'(1);
`endif

  typedef enum logic {IDLE, RUN} state_t;

  // Coefficient applied to butterfly term i for output k: even k use a_i,
  // odd k use d_i, so every coefficient is a plain 4-term dot product.
  function automatic logic [COEF_W-1:0] coef_of(input logic [2:0] k, input logic [1:0] i);
    logic signed [COEF_W-1:0] row [4];
    case (k)
      3'd0:    row = '{C4,  C4,  C4,  C4};
      3'd1:    row = '{C1,  C3,  C5,  C7};
      3'd2:    row = '{C2,  C6, -C6, -C2};
      3'd3:    row = '{C3, -C7, -C1, -C5};
      3'd4:    row = '{C4, -C4, -C4,  C4};
      3'd5:    row = '{C5, -C1,  C7,  C3};
      3'd6:    row = '{C6, -C2,  C2, -C6};
      default: row = '{C7, -C5,  C3, -C1};
    endcase
    return row[i];
  endfunction

  // Input locks
  logic [1:0][7:0][IN_WIDTH-1:0] lock_q, lock_d;
  logic [1:0] full_q, full_d, tuser_p_q, tuser_p_d, tlast_p_q, tlast_p_d;
  logic       wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic [2:0] cnt_q, cnt_d, cur_q, cur_d;
  state_t     state_q, state_d;
  logic       lock_free, in_hs, advance, issue;
  logic [IN_WIDTH-1:0] samp_in;

  // Pipeline
  logic [4:0]                vld_pipe_q, vld_pipe_d;
  logic [3:0][A_W-1:0]       a1_q, a1_d, d1_q, d1_d, op2_q, op2_d;
  logic [2:0]                k1_q, k1_d;
  logic [3:0][COEF_W-1:0]    cf2_q, cf2_d;
  logic [3:0][P_W-1:0]       pr3_q, pr3_d;
  logic [1:0][Q_W-1:0]       ps4_q, ps4_d;
  logic [3:0]                user_q, user_d, last_q, last_d; // S1..S4 flags
  logic [TD_W-1:0]           tdata_q, tdata_d;
  logic                      tlast_q, tlast_d, tuser_q, tuser_d;

  // Unsigned samples are level-shifted by flipping the MSB (x - 2**(W-1)).
  assign samp_in = SIGNED_IN ? video_i_tdata
                             : {~video_i_tdata[IN_WIDTH-1], video_i_tdata[IN_WIDTH-2:0]};

  assign video_i_tready = !rst_i && !full_q[wr_sel_q];
  assign in_hs          = video_i_tvalid && video_i_tready;
  assign advance        = !vld_pipe_q[4] || dct_o_tready;
  assign issue          = advance && full_q[rd_sel_q];

  assign dct_o_tvalid = vld_pipe_q[4];
  assign dct_o_tdata  = tdata_q;
  assign dct_o_tlast  = tlast_q;
  assign dct_o_tuser  = tuser_q;
  assign dct_o_tkeep  = '1;
  assign dct_o_tstrb  = '1;

  // Write side: fill the write lock, replicating each sample forward so an
  // early tlast close leaves the tail edge-padded; close on 8th or tlast.
  always_comb begin
    lock_d    = lock_q;
    full_d    = full_q;
    tuser_p_d = tuser_p_q;
    tlast_p_d = tlast_p_q;
    wr_sel_d  = wr_sel_q;
    cnt_d     = cnt_q;
    if (in_hs) begin
      for (int j = 0; j < 8; j++)
        if (3'(j) >= cnt_q) lock_d[wr_sel_q][j] = samp_in;
      if (cnt_q == 3'd0) begin
        tuser_p_d[wr_sel_q] = video_i_tuser;
        tlast_p_d[wr_sel_q] = video_i_tlast;
      end else begin
        tuser_p_d[wr_sel_q] = tuser_p_q[wr_sel_q] | video_i_tuser;
        tlast_p_d[wr_sel_q] = tlast_p_q[wr_sel_q] | video_i_tlast;
      end
      if (cnt_q == 3'd7 || video_i_tlast) begin
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = ~wr_sel_q;
        cnt_d            = 3'd0;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
    if (lock_free) full_d[rd_sel_q] = 1'b0;
  end

  // Engine FSM: walk cur 0..7 over the read lock; free it at cur=7.
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    rd_sel_d  = rd_sel_q;
    lock_free = 1'b0;
    case (state_q)
      IDLE: if (issue) begin
        cur_d   = 3'd1;
        state_d = RUN;
      end
      RUN: if (issue) begin
        if (cur_q == 3'd7) begin
          lock_free = 1'b1;
          rd_sel_d  = ~rd_sel_q;
          cur_d     = 3'd0;
          state_d   = full_q[~rd_sel_q] ? RUN : IDLE;
        end else begin
          cur_d = cur_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath S1..S5; every stage moves together on advance.
  always_comb begin
    logic signed [IN_WIDTH-1:0] xa, xb;
    logic signed [S_W-1:0]      sum;
    vld_pipe_d = vld_pipe_q;
    a1_d = a1_q;   d1_d = d1_q;   k1_d = k1_q;
    op2_d = op2_q; cf2_d = cf2_q; pr3_d = pr3_q; ps4_d = ps4_q;
    user_d = user_q; last_d = last_q;
    tdata_d = tdata_q; tlast_d = tlast_q; tuser_d = tuser_q;
    xa = '0;
    xb = '0;
    sum = S_W'($signed(ps4_q[0])) + S_W'($signed(ps4_q[1]));
    if (advance) begin
      vld_pipe_d = {vld_pipe_q[3:0], issue};
      for (int i = 0; i < 4; i++) begin
        xa       = $signed(lock_q[rd_sel_q][i]);
        xb       = $signed(lock_q[rd_sel_q][7-i]);
        a1_d[i]  = A_W'(xa) + A_W'(xb);
        d1_d[i]  = A_W'(xa) - A_W'(xb);
        op2_d[i] = k1_q[0] ? d1_q[i] : a1_q[i];
        cf2_d[i] = coef_of(k1_q, 2'(i));
        pr3_d[i] = P_W'($signed(op2_q[i])) * P_W'($signed(cf2_q[i]));
      end
      k1_d      = cur_q;
      user_d    = {user_q[2:0], issue && cur_q == 3'd0 && tuser_p_q[rd_sel_q]};
      last_d    = {last_q[2:0], issue && cur_q == 3'd7 && tlast_p_q[rd_sel_q]};
      ps4_d[0]  = Q_W'($signed(pr3_q[0])) + Q_W'($signed(pr3_q[1]));
      ps4_d[1]  = Q_W'($signed(pr3_q[2])) + Q_W'($signed(pr3_q[3]));
      tdata_d   = TD_W'((sum + (sum[S_W-1] ? NEG_BIAS : POS_BIAS)) >>> SH);
      tlast_d   = last_q[3];
      tuser_d   = user_q[3];
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q <= '0; full_q <= '0; tuser_p_q <= '0; tlast_p_q <= '0;
      wr_sel_q <= 1'b0; rd_sel_q <= 1'b0; cnt_q <= '0; cur_q <= '0;
      state_q <= IDLE;
      vld_pipe_q <= '0;
      a1_q <= '0; d1_q <= '0; k1_q <= '0; op2_q <= '0; cf2_q <= '0;
      pr3_q <= '0; ps4_q <= '0; user_q <= '0; last_q <= '0;
      tdata_q <= '0; tlast_q <= 1'b0; tuser_q <= 1'b0;
    end else begin
      lock_q <= lock_d; full_q <= full_d; tuser_p_q <= tuser_p_d; tlast_p_q <= tlast_p_d;
      wr_sel_q <= wr_sel_d; rd_sel_q <= rd_sel_d; cnt_q <= cnt_d; cur_q <= cur_d;
      state_q <= state_d;
      vld_pipe_q <= vld_pipe_d;
      a1_q <= a1_d; d1_q <= d1_d; k1_q <= k1_d; op2_q <= op2_d; cf2_q <= cf2_d;
      pr3_q <= pr3_d; ps4_q <= ps4_d; user_q <= user_d; last_q <= last_d;
      tdata_q <= tdata_d; tlast_q <= tlast_d; tuser_q <= tuser_d;
    end
  end

endmodule

// File: tb/tb_dct_1d_stage.sv
// tb_dct_1d_stage: scoreboard bench for dct_1d_stage (default parameters).
// Expected coefficients come from the floating-point DCT-II definition.
module tb_dct_1d_stage;
  localparam int TD_W = 24;
  localparam real TOL = 1.05;   // output LSBs

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      v_tdata = '0;
  logic            v_tvalid = 1'b0, v_tlast = 1'b0, v_tuser = 1'b0, v_tready;
  logic [TD_W-1:0] d_tdata;
  logic [2:0]      d_tkeep, d_tstrb;
  logic            d_tvalid, d_tlast, d_tuser;
  logic            d_tready = 1'b1;

  always #5 clk = ~clk;

  dct_1d_stage dut (
    .clk_i(clk), .rst_i(rst),
    .video_i_tdata(v_tdata), .video_i_tvalid(v_tvalid), .video_i_tlast(v_tlast),
    .video_i_tuser(v_tuser), .video_i_tready(v_tready),
    .dct_o_tdata(d_tdata), .dct_o_tkeep(d_tkeep), .dct_o_tstrb(d_tstrb),
    .dct_o_tvalid(d_tvalid), .dct_o_tlast(d_tlast), .dct_o_tuser(d_tuser),
    .dct_o_tready(d_tready)
  );

  typedef struct { real data; bit last; bit user; } exp_t;
  exp_t sbq[$];
  int   pack[$];
  bit   pk_user = 0, pk_last = 0;
  int   n_cmp = 0, n_err = 0, out_cnt = 0;
  bit   rnd_ready = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: collect a pack, edge-pad short lines, evaluate the DCT-II.
  task automatic model_accept(input int s, input bit l, input bit u);
    pack.push_back(s);
    pk_user |= u;
    pk_last |= l;
    if (pack.size() == 8 || l) begin
      while (pack.size() < 8) pack.push_back(pack[pack.size()-1]);
      for (int k = 0; k < 8; k++) begin
        exp_t e;
        real acc = 0.0;
        for (int n = 0; n < 8; n++)
          acc += real'(pack[n] - 128) * $cos(real'((2*n+1)*k) * 3.141592653589793 / 16.0);
        acc = acc * 0.5;
        if (k == 0) acc = acc * 0.7071067811865476;
        e.data = acc * 256.0;
        e.last = (k == 7) && pk_last;
        e.user = (k == 0) && pk_user;
        sbq.push_back(e);
      end
      pack.delete();
      pk_user = 0;
      pk_last = 0;
    end
  endtask

  task automatic send(input int s, input bit l, input bit u, input bit chk_rdy);
    int w = 0;
    @(negedge clk);
    v_tvalid = 1'b1; v_tdata = s[7:0]; v_tlast = l; v_tuser = u;
    if (chk_rdy) chk("tready_sustained", v_tready, 1);
    while (!v_tready && w < 300) begin @(negedge clk); w++; end
    if (!v_tready) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: tready %0b after %0d cycles, expected 1", v_tready, w);
      v_tvalid = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(s, l, u);
  endtask

  task automatic idle();
    @(negedge clk);
    v_tvalid = 1'b0; v_tlast = 1'b0; v_tuser = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sbq.size() != 0 && w < 1000) begin @(negedge clk); w++; end
    chk("drain_pending", sbq.size(), 0);
    repeat (10) @(negedge clk);
  endtask

  // Output backpressure driver
  initial begin
    forever begin
      @(posedge clk);
      #2 d_tready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor: pop and compare on each output handshake; check hold while stalled.
  logic [TD_W-1:0] held_d;
  bit held_l, held_u, stalled = 0;
  always @(negedge clk) begin
    if (rst) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        chk("hold_valid", d_tvalid, 1);
        chk("hold_data", d_tdata, held_d);
        chk("hold_flags", {d_tlast, d_tuser}, {held_l, held_u});
      end
      stalled = 0;
      if (d_tvalid && d_tready) begin
        out_cnt++;
        n_cmp++;
        if (sbq.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output: got data %0d, expected no output", $signed(d_tdata));
        end else begin
          exp_t e;
          real act, diff;
          e    = sbq.pop_front();
          act  = real'(int'($signed(d_tdata)));
          diff = act - e.data;
          if (diff < 0.0) diff = -diff;
          if (diff > TOL || d_tlast != e.last || d_tuser != e.user) begin
            n_err++;
            $display("FAIL coef: got %0d last %0b user %0b, expected %0.2f last %0b user %0b",
                     $signed(d_tdata), d_tlast, d_tuser, e.data, e.last, e.user);
          end
        end
      end else if (d_tvalid) begin
        stalled = 1;
        held_d = d_tdata; held_l = d_tlast; held_u = d_tuser;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, base;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", d_tvalid, 0);
    chk("rst_tready", v_tready, 0);
    chk("rst_tdata", d_tdata, 0);
    chk("rst_tlast", d_tlast, 0);
    chk("rst_tuser", d_tuser, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("tready_after_reset", v_tready, 1);

    // 8 x 128: all zero, tlast on F7, tuser on F0
    for (int i = 0; i < 8; i++) send(128, i == 7, i == 0, 0);
    idle();
    drain();

    // 8 x 255 with latency measurement from the closing handshake
    for (int i = 0; i < 8; i++) send(255, 0, 0, 0);
    #1 v_tvalid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1 lat++;
      if (d_tvalid) break;
    end
    chk("latency", lat, 5);
    drain();

    // Impulse, then short line, then a fresh random line
    send(255, 0, 0, 0);
    for (int i = 0; i < 7; i++) send(128, 0, 0, 0);
    for (int i = 0; i < 3; i++) send(255, i == 2, 0, 0);
    for (int i = 0; i < 8; i++) send($urandom_range(0, 255), i == 7, 0, 0);
    idle();
    drain();

    // 64 samples back to back: no input stall, 64 contiguous outputs
    fork
      begin
        for (int i = 0; i < 64; i++) send($urandom_range(0, 255), i == 63, i == 0, 1);
        idle();
      end
      begin
        int w = 0;
        while (!d_tvalid && w < 60) begin @(negedge clk); w++; end
        for (int i = 0; i < 64; i++) begin
          chk("contig_valid", d_tvalid, 1);
          @(negedge clk);
        end
      end
    join
    drain();

    // Random backpressure with random-length lines
    rnd_ready = 1;
    for (int ln = 0; ln < 8; ln++) begin
      int len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++)
        send($urandom_range(0, 255), i == len - 1, (ln == 0) && (i == 0), 0);
    end
    idle();
    drain();

    // Reset mid-pack discards it; next 8 x 255 produces exactly 8 outputs
    for (int i = 0; i < 4; i++) send($urandom_range(0, 255), 0, 0, 0);
    @(negedge clk);
    rst = 1'b1; v_tvalid = 1'b0;
    pack.delete(); pk_user = 0; pk_last = 0; sbq.delete();
    repeat (2) @(negedge clk);
    chk("midrst_tvalid", d_tvalid, 0);
    chk("midrst_tready", v_tready, 0);
    rst = 1'b0;
    base = out_cnt;
    for (int i = 0; i < 8; i++) send(255, i == 7, 0, 0);
    idle();
    drain();
    chk("post_reset_count", out_cnt - base, 8);
    rnd_ready = 0;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
